// File: rtl/mult_acc_pkg.sv
// Shared types and default sizes for the product accumulator.
package mult_acc_pkg;

  localparam int DEFAULT_PROD_W = 8;
  localparam int DEFAULT_ACC_W  = 2 * DEFAULT_PROD_W;
  localparam int DEFAULT_CNT_W  = 4;

  localparam logic [DEFAULT_ACC_W-1:0] ACC_MAX = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READ_LO = 2'd1,
    READ_HI = 2'd2
  } state_e;

endpackage

// File: rtl/mult_acc_sat_add.sv
// Combinational saturating adder: accumulator plus zero-extended product.
module mult_acc_sat_add #(
  parameter int ACC_W  = 16,
  parameter int PROD_W = 8
) (
  input  logic [ACC_W-1:0]  acc_i,
  input  logic [PROD_W-1:0] prod_i,
  output logic [ACC_W-1:0]  sum_o,
  output logic              sat_o
);

  logic [ACC_W:0] full_sum;

  // One extra bit catches the carry that signals the true sum left the range.
  assign full_sum = {1'b0, acc_i} + {{(ACC_W + 1 - PROD_W){1'b0}}, prod_i};
  assign sat_o    = full_sum[ACC_W];
  assign sum_o    = sat_o ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];

endmodule

// File: rtl/mult_product_accumulator.sv
// Saturating MAC back end: accumulates products, reads the sum out low byte then high byte.
module mult_product_accumulator
  import mult_acc_pkg::*;
#(
  parameter int PROD_W = DEFAULT_PROD_W,
  parameter int ACC_W  = DEFAULT_ACC_W,
  parameter int CNT_W  = DEFAULT_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prod_valid,
  input  logic [PROD_W-1:0] prod_in,
  output logic              prod_ready,
  input  logic              clear,
  input  logic              rd_start,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [PROD_W-1:0] rd_data,
  output logic              rd_last,
  output logic              busy,
  output logic              overflow,
  output logic [CNT_W-1:0]  count
);

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              rd_valid_q, rd_valid_d;
  logic              rd_last_q, rd_last_d;
  logic [PROD_W-1:0] rd_data_q, rd_data_d;

  logic [ACC_W-1:0]  sat_sum;
  logic              sat_hit;
  logic              accept;

  assign prod_ready = (state_q == IDLE) & ~rst & ~clear;
  assign accept     = prod_valid & prod_ready;

  mult_acc_sat_add #(
    .ACC_W  (ACC_W),
    .PROD_W (PROD_W)
  ) u_sat_add (
    .acc_i  (acc_q),
    .prod_i (prod_in),
    .sum_o  (sat_sum),
    .sat_o  (sat_hit)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latch).
    state_d    = state_q;
    acc_d      = acc_q;
    count_d    = count_q;
    ovf_d      = ovf_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;

    if (clear) begin
      state_d    = IDLE;
      acc_d      = '0;
      count_d    = '0;
      ovf_d      = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
      rd_data_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            acc_d = sat_sum;
            ovf_d = ovf_q | sat_hit;
            if (count_q != {CNT_W{1'b1}}) count_d = count_q + 1'b1;
          end
          // The low beat uses acc_d so a product accepted this cycle is part of the sum.
          if (rd_start) begin
            state_d    = READ_LO;
            rd_valid_d = 1'b1;
            rd_last_d  = 1'b0;
            rd_data_d  = acc_d[PROD_W-1:0];
          end
        end
        READ_LO: begin
          if (rd_ready) begin
            state_d   = READ_HI;
            rd_last_d = 1'b1;
            rd_data_d = acc_q[ACC_W-1:PROD_W];
          end
        end
        READ_HI: begin
          if (rd_ready) begin
            state_d    = IDLE;
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            rd_data_d  = '0;
            acc_d      = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      acc_q      <= '0;
      count_q    <= '0;
      ovf_q      <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      count_q    <= count_d;
      ovf_q      <= ovf_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_last  = rd_last_q;
  assign rd_data  = rd_data_q;
  assign busy     = (state_q != IDLE);
  assign overflow = ovf_q;
  assign count    = count_q;

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Self-checking bench: directed scenarios plus randomized bursts against an arithmetic model.
module tb_mult_product_accumulator;

  localparam int PROD_W = 8;
  localparam int ACC_W  = 16;
  localparam int CNT_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              prod_valid;
  logic [PROD_W-1:0] prod_in;
  logic              prod_ready;
  logic              clear;
  logic              rd_start;
  logic              rd_ready;
  logic              rd_valid;
  logic [PROD_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;
  logic              overflow;
  logic [CNT_W-1:0]  count;

  int checks = 0;
  int errors = 0;

  // Reference model: plain integer sum clipped to 16 bits, sticky flag, clipped counter.
  int unsigned m_acc;
  int unsigned m_cnt;
  logic        m_ovf;

  mult_product_accumulator #(
    .PROD_W (PROD_W),
    .ACC_W  (ACC_W),
    .CNT_W  (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .prod_valid (prod_valid),
    .prod_in    (prod_in),
    .prod_ready (prod_ready),
    .clear      (clear),
    .rd_start   (rd_start),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .busy       (busy),
    .overflow   (overflow),
    .count      (count)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic m_add(input int unsigned p);
    int unsigned s;
    s = m_acc + p;
    if (s > 65535) begin
      m_acc = 65535;
      m_ovf = 1'b1;
    end else begin
      m_acc = s;
    end
    if (m_cnt < 15) m_cnt++;
  endtask

  task automatic m_zero();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  task automatic check_status(input string tag);
    check({tag, "_count"}, 32'(count), m_cnt);
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
  endtask

  task automatic push(input logic [7:0] p);
    prod_valid = 1'b1;
    prod_in    = p;
    #1;
    check("push_ready", 32'(prod_ready), 1);
    tick();
    m_add(p);
    prod_valid = 1'b0;
  endtask

  // Full readout; optional product in the rd_start cycle and optional stall in READ_LO.
  task automatic readout(input string tag, input int stall, input bit with_prod, input logic [7:0] p);
    logic [7:0] lo;
    rd_ready   = 1'b0;
    rd_start   = 1'b1;
    prod_valid = with_prod;
    prod_in    = p;
    tick();
    rd_start   = 1'b0;
    prod_valid = 1'b0;
    if (with_prod) m_add(p);
    lo = 8'(m_acc & 32'hFF);
    check({tag, "_lo_valid"}, 32'(rd_valid), 1);
    check({tag, "_lo_data"}, 32'(rd_data), 32'(lo));
    check({tag, "_lo_last"}, 32'(rd_last), 0);
    check({tag, "_busy"}, 32'(busy), 1);
    check_status({tag, "_pre"});
    for (int i = 0; i < stall; i++) begin
      prod_valid = 1'b1;
      prod_in    = 8'($urandom_range(0, 255));
      rd_start   = 1'($urandom_range(0, 1));
      #1;
      check({tag, "_stall_ready"}, 32'(prod_ready), 0);
      tick();
      check({tag, "_stall_data"}, 32'(rd_data), 32'(lo));
      check({tag, "_stall_valid"}, 32'(rd_valid), 1);
    end
    prod_valid = 1'b0;
    rd_start   = 1'b0;
    rd_ready   = 1'b1;
    tick();
    check({tag, "_hi_valid"}, 32'(rd_valid), 1);
    check({tag, "_hi_data"}, 32'(rd_data), (m_acc >> 8) & 32'hFF);
    check({tag, "_hi_last"}, 32'(rd_last), 1);
    tick();
    rd_ready = 1'b0;
    m_zero();
    check({tag, "_done_valid"}, 32'(rd_valid), 0);
    check({tag, "_done_busy"}, 32'(busy), 0);
    check_status({tag, "_post"});
  endtask

  initial begin
    rst        = 1'b1;
    prod_valid = 1'b0;
    prod_in    = '0;
    clear      = 1'b0;
    rd_start   = 1'b0;
    rd_ready   = 1'b0;
    m_zero();

    repeat (2) tick();
    check("rst_ready", 32'(prod_ready), 0);
    check("rst_valid", 32'(rd_valid), 0);
    check("rst_data", 32'(rd_data), 0);
    check("rst_last", 32'(rd_last), 0);
    check("rst_busy", 32'(busy), 0);
    check_status("rst");
    rst = 1'b0;
    #1;
    check("rst_release_ready", 32'(prod_ready), 1);

    // Reset asserted mid-readout aborts it.
    push(8'h12);
    push(8'h34);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("midrst_busy_before", 32'(busy), 1);
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(rd_valid), 0);
    check("midrst_data", 32'(rd_data), 0);
    check("midrst_last", 32'(rd_last), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_ready", 32'(prod_ready), 0);
    m_zero();
    check_status("midrst");
    repeat (2) tick();
    check("midrst_ready_held", 32'(prod_ready), 0);
    rst = 1'b0;
    #1;
    check("midrst_ready_after", 32'(prod_ready), 1);
    readout("midrst_rd", 0, 1'b0, 8'h00);

    // Three products of 0xE1 sum to 0x02A3.
    repeat (3) push(8'hE1);
    check("e1_count", 32'(count), 3);
    rd_ready = 1'b0;
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    check("e1_lo", 32'(rd_data), 32'hA3);
    check("e1_lo_last", 32'(rd_last), 0);
    rd_ready = 1'b1;
    tick();
    check("e1_hi", 32'(rd_data), 32'h02);
    check("e1_hi_last", 32'(rd_last), 1);
    tick();
    rd_ready = 1'b0;
    check("e1_count_after", 32'(count), 0);
    m_zero();

    // 257 x 0xFF lands exactly on 0xFFFF; one more saturates.
    repeat (257) push(8'hFF);
    check("sat_edge_overflow", 32'(overflow), 0);
    check("sat_edge_count", 32'(count), 15);
    push(8'h01);
    check("sat_overflow", 32'(overflow), 1);
    check("sat_count", 32'(count), 15);
    push(8'h00);
    check("sat_overflow_sticky", 32'(overflow), 1);
    check("sat_model_acc", 32'(m_acc), 32'hFFFF);
    readout("sat_rd", 0, 1'b0, 8'h00);

    // Product accepted in the rd_start cycle is included.
    readout("same_cycle", 0, 1'b1, 8'h10);

    // Stalled low beat.
    push(8'h9C);
    push(8'h47);
    readout("stall", 5, 1'b0, 8'h00);

    // Clear in READ_HI aborts the readout and zeroes everything.
    push(8'h77);
    push(8'h88);
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("clr_in_hi_last", 32'(rd_last), 1);
    clear = 1'b1;
    #1;
    check("clr_ready", 32'(prod_ready), 0);
    tick();
    clear = 1'b0;
    m_zero();
    check("clr_valid", 32'(rd_valid), 0);
    check("clr_busy", 32'(busy), 0);
    check_status("clr");
    readout("clr_rd", 0, 1'b0, 8'h00);

    // Clear in IDLE drops a simultaneous product and rd_start.
    push(8'h05);
    prod_valid = 1'b1;
    prod_in    = 8'hAA;
    rd_start   = 1'b1;
    clear      = 1'b1;
    #1;
    check("clr_idle_ready", 32'(prod_ready), 0);
    tick();
    prod_valid = 1'b0;
    rd_start   = 1'b0;
    clear      = 1'b0;
    m_zero();
    check("clr_idle_busy", 32'(busy), 0);
    check_status("clr_idle");

    // Randomized bursts with idle gaps, occasional clears and stalls.
    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++) begin
        push(8'($urandom_range(0, 255)));
        repeat ($urandom_range(0, 2)) tick();
      end
      check_status("rnd_burst");
      if ($urandom_range(0, 4) == 0) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_zero();
        check_status("rnd_clear");
      end
      readout("rnd_rd", $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
